// File: rtl/matrix_engine_p.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_engine_p : descriptor-driven MUL/MAC/ADD/MULT matrix engine         |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module matrix_engine_p #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                ACC_W     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                SATURATE  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE, FETCH, CHECK, LOOP_I, LOOP_J, LOAD_C, LOOP_K, LOAD_A, LOAD_B, ACCUM, WRITE, DONE
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     state, state_nx;
  logic [DATA_W-1:0]          width_a, height_a, width_b, height_b;
  logic [1:0]                 mode;
  logic [2:0]                 fetch_idx;
  logic [DATA_W-1:0]          i, j, k;
  logic signed [DATA_W-1:0]   a_val, b_val;
  logic signed [ACC_W-1:0]    acc;

  logic                       xfer_done, mem_state, desc_bad, last_elem;
  logic [DATA_W-1:0]          j_lim;
  logic [ADDR_W-1:0]          a_base, b_base, c_base, req_addr;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, sum_ext;
  logic [DATA_W-1:0]          sat_val;

  function automatic logic [ADDR_W-1:0] lin(input logic [ADDR_W-1:0] base,
                                            input logic [DATA_W-1:0] row,
                                            input logic [DATA_W-1:0] stride,
                                            input logic [DATA_W-1:0] col);
    return base + ADDR_W'(row) * ADDR_W'(stride) + ADDR_W'(col);
  endfunction

  assign a_base    = BASE_ADDR + ADDR_W'(5);
  assign b_base    = lin(a_base, height_a, width_a, DATA_W'(0));
  assign c_base    = lin(b_base, height_b, width_b, DATA_W'(0));
  assign j_lim     = (mode == 2'd2) ? width_a : width_b;
  assign xfer_done = (mem_operation != OP_NONE) && mem_opdone;
  assign mem_state = (state == FETCH) || (state == LOAD_C) || (state == LOAD_A) ||
                     (state == LOAD_B) || (state == WRITE);
  assign last_elem = (i == height_a - DATA_W'(1)) && (j == j_lim - DATA_W'(1));
  assign desc_bad  = (width_a == '0) || (height_a == '0) || (width_b == '0) || (height_b == '0) ||
                     ((mode == 2'd2) ? ((height_a != height_b) || (width_a != width_b))
                                     : (width_a != height_b));

  assign prod     = a_val * b_val;
  assign prod_ext = ACC_W'(prod);
  assign sum_ext  = ACC_W'(a_val) + ACC_W'(b_val);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_comb begin
    sat_val = acc[DATA_W-1:0];
    if (SATURATE) begin
      if (acc > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
      else if (acc < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    end
  end

  // Address of the access the current state will issue.
  always_comb begin
    req_addr = '0;
    case (state)
      FETCH:         req_addr = BASE_ADDR + ADDR_W'(fetch_idx);
      LOAD_C, WRITE: req_addr = lin(c_base, i, width_b, j);
      LOAD_A:        req_addr = lin(a_base, i, width_a, (mode == 2'd2) ? j : k);
      LOAD_B: begin
        case (mode)
          2'd3:    req_addr = lin(b_base, j, height_b, k);
          2'd2:    req_addr = lin(b_base, i, width_b, j);
          default: req_addr = lin(b_base, k, width_b, j);
        endcase
      end
      default:       req_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (enable) state_nx = FETCH;
      FETCH:  if (xfer_done && fetch_idx == 3'd4) state_nx = CHECK;
      CHECK:  state_nx = desc_bad ? DONE : LOOP_I;
      LOOP_I: state_nx = (i == height_a) ? DONE : LOOP_J;
      LOOP_J: begin
        if (j == j_lim)       state_nx = LOOP_I;
        else if (mode == 2'd1) state_nx = LOAD_C;
        else if (mode == 2'd2) state_nx = LOAD_A;
        else                   state_nx = LOOP_K;
      end
      LOAD_C: if (xfer_done) state_nx = LOOP_K;
      LOOP_K: state_nx = (k == width_a) ? WRITE : LOAD_A;
      LOAD_A: if (xfer_done) state_nx = LOAD_B;
      LOAD_B: if (xfer_done) state_nx = ACCUM;
      ACCUM:  state_nx = (mode == 2'd2) ? WRITE : LOOP_K;
      WRITE:  if (xfer_done) state_nx = last_elem ? DONE : LOOP_J;
      DONE:   if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_operation <= OP_NONE;
      addr_o        <= '0;
      data_o        <= '0;
      error         <= 1'b0;
      width_a       <= '0;
      height_a      <= '0;
      width_b       <= '0;
      height_b      <= '0;
      mode          <= 2'd0;
      fetch_idx     <= 3'd0;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      a_val         <= '0;
      b_val         <= '0;
      acc           <= '0;
    end else begin
      // A request issues only from an idle bus, so every completion leaves a gap cycle.
      if (mem_state) begin
        if (mem_operation == OP_NONE) begin
          mem_operation <= (state == WRITE) ? OP_WRITE : OP_READ;
          addr_o        <= req_addr;
          if (state == WRITE) data_o <= sat_val;
        end else if (mem_opdone) begin
          mem_operation <= OP_NONE;
        end
      end

      case (state)
        IDLE: begin
          if (enable) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            error     <= 1'b0;
            fetch_idx <= 3'd0;
          end
        end
        FETCH: begin
          if (xfer_done) begin
            case (fetch_idx)
              3'd0:    width_a  <= data_i;
              3'd1:    height_a <= data_i;
              3'd2:    width_b  <= data_i;
              3'd3:    height_b <= data_i;
              default: mode     <= data_i[1:0];
            endcase
            fetch_idx <= fetch_idx + 3'd1;
          end
        end
        CHECK: begin
          if (desc_bad) error <= 1'b1;
          i <= '0;
        end
        LOOP_I: j <= '0;
        LOOP_J: begin
          if (j == j_lim) begin
            i <= i + DATA_W'(1);
          end else begin
            acc <= '0;
            k   <= '0;
          end
        end
        LOAD_C: if (xfer_done) acc <= ACC_W'($signed(data_i));
        LOAD_A: if (xfer_done) a_val <= data_i;
        LOAD_B: if (xfer_done) b_val <= data_i;
        ACCUM: begin
          if (mode == 2'd2) begin
            acc <= sum_ext;
          end else begin
            acc <= acc + prod_ext;
            k   <= k + DATA_W'(1);
          end
        end
        WRITE: if (xfer_done) j <= j + DATA_W'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_engine_p.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_engine_p : directed bench for matrix_engine_p (8-bit build)      |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_matrix_engine_p;

  localparam int         DW = 8;
  localparam int         AW = 8;
  localparam int         ACCW = 16;
  localparam logic [7:0] BA = 8'd16;
  localparam logic [7:0] AB = BA + 8'd5;   // A base for 2x2 jobs
  localparam logic [7:0] BB = BA + 8'd9;   // B base for 2x2 jobs
  localparam logic [7:0] CB = BA + 8'd13;  // C base for 2x2 jobs

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic sel = 1'b0;
  logic rand_en = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  logic [7:0] mem [0:255] = '{default: 8'h00};
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = 8'h00;
  logic [7:0] tb_wd = 8'h00;
  logic [2:0] wait_cnt = 3'd0;
  int         wr_cycles = 0;

  logic [DW-1:0] dout_s, dout_t, din;
  logic [AW-1:0] addr_s, addr_t;
  logic [1:0]    op_s, op_t;
  logic          busy_s, busy_t, done_s, done_t, err_s, err_t;
  logic [1:0]    cur_op;
  logic [7:0]    cur_addr, cur_dout;
  logic          cur_busy, cur_done, cur_err, opdone;

  assign cur_op   = sel ? op_t   : op_s;
  assign cur_addr = sel ? addr_t : addr_s;
  assign cur_dout = sel ? dout_t : dout_s;
  assign cur_busy = sel ? busy_t : busy_s;
  assign cur_done = sel ? done_t : done_s;
  assign cur_err  = sel ? err_t  : err_s;
  assign opdone   = (cur_op != 2'b00) && (wait_cnt == 3'd0);
  assign din      = mem[cur_addr];

  matrix_engine_p #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .BASE_ADDR(BA), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable & ~sel), .mem_opdone(opdone & ~sel),
    .data_i(din), .data_o(dout_s), .addr_o(addr_s), .mem_operation(op_s),
    .busy(busy_s), .done(done_s), .error(err_s));

  matrix_engine_p #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .BASE_ADDR(BA), .SATURATE(1'b0)) dut_t (
    .clk(clk), .reset_n(reset_n), .enable(enable & sel), .mem_opdone(opdone & sel),
    .data_i(din), .data_o(dout_t), .addr_o(addr_t), .mem_operation(op_t),
    .busy(busy_t), .done(done_t), .error(err_t));

  // Memory model: wait states drawn while the bus is idle, writes land on completion.
  always @(posedge clk) begin
    if (cur_op == 2'b00) wait_cnt <= rand_en ? 3'($urandom_range(0, 7)) : 3'd0;
    else if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
    if (cur_op == 2'b11) begin
      wr_cycles = wr_cycles + 1;
      if (opdone) mem[cur_addr] = cur_dout;
    end
    if (tb_we) mem[tb_wa] = tb_wd;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic set_desc(input logic [7:0] wa, ha, wb, hb, md);
    poke(BA, wa); poke(BA + 8'd1, ha); poke(BA + 8'd2, wb);
    poke(BA + 8'd3, hb); poke(BA + 8'd4, md);
  endtask

  task automatic load2(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3, c);
    poke(AB, a0); poke(AB + 8'd1, a1); poke(AB + 8'd2, a2); poke(AB + 8'd3, a3);
    poke(BB, b0); poke(BB + 8'd1, b1); poke(BB + 8'd2, b2); poke(BB + 8'd3, b3);
    poke(CB, c);  poke(CB + 8'd1, c);  poke(CB + 8'd2, c);  poke(CB + 8'd3, c);
  endtask

  task automatic check_c2(input string tag, input logic [7:0] e0, e1, e2, e3);
    check({tag, " c00"}, mem[CB], e0);
    check({tag, " c01"}, mem[CB + 8'd1], e1);
    check({tag, " c10"}, mem[CB + 8'd2], e2);
    check({tag, " c11"}, mem[CB + 8'd3], e3);
  endtask

  task automatic run_job(input string tag, input logic exp_err);
    bit got;
    got = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      got = cur_done;
    end
    check({tag, " done"}, got, 1);
    check({tag, " error"}, cur_err, exp_err);
    repeat (3) @(negedge clk);
    check({tag, " hold_done"}, cur_done, 1);
    check({tag, " hold_busy"}, cur_busy, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " idle"}, cur_done, 0);
  endtask

  initial begin
    int wr0;
    bit seen;

    // Reset state and no self-start with enable low
    repeat (3) @(negedge clk);
    check("rst op", op_s, 2'b00);
    check("rst addr", addr_s, 0);
    check("rst data", dout_s, 0);
    check("rst busy", busy_s, 0);
    check("rst done", done_s, 0);
    check("rst error", err_s, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_start busy", busy_s, 0);

    // MUL
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'd0);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0);
    run_job("mul", 1'b0);
    check_c2("mul", 8'd19, 8'd22, 8'd43, 8'd50);

    // MAC onto ones; upper mode bits ignored
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'hF5);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd1);
    run_job("mac", 1'b0);
    check_c2("mac", 8'd20, 8'd23, 8'd44, 8'd51);

    // MULT with transposed B
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'd3);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd6, 8'd8, 8'd0);
    run_job("mult", 1'b0);
    check_c2("mult", 8'd19, 8'd22, 8'd43, 8'd50);

    // ADD
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'd2);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0);
    run_job("add", 1'b0);
    check_c2("add", 8'd6, 8'd8, 8'd10, 8'd12);

    // Rejected descriptors: mismatch and zero dimension, no writes
    set_desc(8'd3, 8'd2, 8'd2, 8'd2, 8'd0);
    wr0 = wr_cycles;
    run_job("bad_dim", 1'b1);
    check("bad_dim writes", wr_cycles - wr0, 0);
    set_desc(8'd0, 8'd2, 8'd2, 8'd2, 8'd0);
    wr0 = wr_cycles;
    run_job("zero_dim", 1'b1);
    check("zero_dim writes", wr_cycles - wr0, 0);

    // Saturation / truncation on 1x1 (A at BA+5, B at BA+6, C at BA+7)
    set_desc(8'd1, 8'd1, 8'd1, 8'd1, 8'd0);
    poke(AB, 8'd100); poke(AB + 8'd1, 8'd2); poke(AB + 8'd2, 8'd0);
    run_job("sat_pos", 1'b0);
    check("sat_pos c", mem[AB + 8'd2], 8'h7F);
    poke(AB, 8'h9C); poke(AB + 8'd2, 8'd0);
    run_job("sat_neg", 1'b0);
    check("sat_neg c", mem[AB + 8'd2], 8'h80);
    sel = 1'b1;
    poke(AB, 8'd100); poke(AB + 8'd2, 8'd0);
    run_job("trunc", 1'b0);
    check("trunc c", mem[AB + 8'd2], 8'hC8);
    sel = 1'b0;

    // Random wait states
    rand_en = 1'b1;
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'd0);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0);
    run_job("mul_w", 1'b0);
    check_c2("mul_w", 8'd19, 8'd22, 8'd43, 8'd50);
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'd1);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd1);
    run_job("mac_w", 1'b0);
    check_c2("mac_w", 8'd20, 8'd23, 8'd44, 8'd51);

    // Reset asserted while a write is outstanding
    set_desc(8'd2, 8'd2, 8'd2, 8'd2, 8'd0);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0);
    @(negedge clk);
    enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      seen = (op_s == 2'b11);
    end
    check("rstw saw_write", seen, 1);
    reset_n = 1'b0;
    #1;
    check("rstw op", op_s, 2'b00);
    check("rstw busy", busy_s, 0);
    check("rstw addr", addr_s, 0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstw idle", busy_s, 0);
    load2(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0);
    run_job("after_rst", 1'b0);
    check_c2("after_rst", 8'd19, 8'd22, 8'd43, 8'd50);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_engine_p.md
MATRIX_ENGINE_P -- requirements
Module: matrix_engine_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning element/data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning word address width.
REQ-003 SHALL have parameter ACC_W, default 64, meaning internal signed accumulator width (≥ 2*DATA_W).
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning word address of the 5-word descriptor.
REQ-005 SHALL have parameter SATURATE, default 1, meaning 1 = clamp results to signed DATA_W range and 0 = truncate.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit, meaning reset, asynchronous assert and active-low.
REQ-008 SHALL have port enable, input, 1 bit, meaning level start request.
REQ-009 SHALL have port mem_opdone, input, 1 bit, meaning memory completion strobe for the current operation.
REQ-010 SHALL have port data_i, input, DATA_W bits, meaning read data, valid when mem_opdone=1 on a read.
REQ-011 SHALL have port data_o, output, DATA_W bits, meaning write data.
REQ-012 SHALL have port addr_o, output, ADDR_W bits, meaning word address.
REQ-013 SHALL have port mem_operation, output, 2 bits, meaning 00 none, 01 read, 11 write (10 never driven).
REQ-014 SHALL have port busy, output, 1 bit, meaning high in every state except IDLE and DONE.
REQ-015 SHALL have port done, output, 1 bit, meaning job complete, held in DONE.
REQ-016 SHALL have port error, output, 1 bit, meaning descriptor rejected, valid while done=1.

Function
REQ-017 SHALL define the descriptor words at BASE_ADDR+0..4 as width_a, height_a, width_b, height_b, mode[1:0]; upper mode bits are ignored.
REQ-018 SHALL compute a_base=BASE_ADDR+5, b_base=a_base+height_a*width_a, and c_base=b_base+height_b*width_b, truncated to ADDR_W.
REQ-019 SHALL support mode 0 MUL: C[i][j]=sum_k A[i][k]*B[k][j].
REQ-020 SHALL support mode 1 MAC: C[i][j]=C_old[i][j]+sum_k A[i][k]*B[k][j], with C_old read from c_base before the k loop.
REQ-021 SHALL support mode 2 ADD: C[i][j]=A[i][j]+B[i][j], with no k loop.
REQ-022 SHALL support mode 3 MULT: as MUL, but B[k][j] is read at b_base+j*height_b+k (B stored transposed).
REQ-023 SHALL use address A[i][k]=a_base+i*width_a+k, B[k][j]=b_base+k*width_b+j (modes 0/1), B[i][j]=b_base+i*width_b+j (mode 2), and C[i][j]=c_base+i*width_b+j.
REQ-024 SHALL treat operands as signed DATA_W, form each product at full 2*DATA_W, sign-extend to ACC_W, and let the accumulator wrap modulo 2^ACC_W.
REQ-025 SHALL write data_o as the accumulator clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when SATURATE=1, else as its low DATA_W bits.
REQ-026 SHALL implement states IDLE, FETCH, CHECK, LOOP_I, LOOP_J, LOAD_C, LOOP_K, LOAD_A, LOAD_B, ACCUM, WRITE, DONE.
REQ-027 SHALL transition IDLE→FETCH when enable=1, clearing i, j, k, accumulator and error.
REQ-028 SHALL read five descriptor words in order in FETCH, then enter CHECK.
REQ-029 SHALL, in CHECK, set error=1 and go to DONE with no writes if any dimension is 0, if width_a≠height_b in modes 0/1, or if height_a≠height_b or width_a≠width_b in mode 2.
REQ-030 SHALL, in CHECK for mode 3, require width_a=height_b as logical dimensions, and otherwise go to LOOP_I.
REQ-031 SHALL loop in order i over height_a (outer), j over width_b (mode 2: width_a), and k over width_a (inner).
REQ-032 SHALL, per element, clear the accumulator, do LOAD_C in mode 1 only, then run the k loop, then WRITE, then j+1.
REQ-033 SHALL, in mode 2, do LOAD_A, LOAD_B, ACCUM (sum) once, then WRITE.
REQ-034 SHALL take exactly one cycle for ACCUM.
REQ-035 SHALL use this handshake: drive mem_operation and addr_o (and data_o on writes), hold all stable until mem_opdone=1 is sampled, capture data_i that same edge, then drive mem_operation=00 for at least one cycle before the next request.
REQ-036 SHALL ignore mem_opdone while mem_operation=00.
REQ-037 SHALL tolerate arbitrary wait states, including mem_opdone in the first request cycle.
REQ-038 SHALL, in DONE, hold done=1 and error stable until enable=0, then go to IDLE; enable held high SHALL NOT restart a job.
REQ-039 SHALL enter DONE after writing the last element (i=height_a-1, j=last); if LOOP_I is reached with i=height_a, it SHALL go to DONE.

Reset
REQ-040 SHALL, on reset_n low, immediately force state=IDLE; mem_operation=00, addr_o=0, data_o=0, busy=0, done=0, error=0; and all indices, dimensions and the accumulator to 0.
REQ-041 SHALL, on reset mid-transfer, abort the outstanding memory operation (mem_operation to 00 asynchronously) and never resume it.
REQ-042 SHALL leave IDLE on the first rising edge after reset_n deasserts only if enable=1.

Verification
REQ-043 SHALL verify mode 0 with A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]] at c_base..+3, error=0.
REQ-044 SHALL verify mode 1 with the same A,B and C preloaded [[1,1],[1,1]] -> C=[[20,23],[44,51]].
REQ-045 SHALL verify mode 3 with B stored [[5,7],[6,8]] -> C=[[19,22],[43,50]], and mode 2 with the same A,B -> C=[[6,8],[10,12]].
REQ-046 SHALL verify that width_a=3, height_b=2, mode 0 -> done=1, error=1, and no mem_operation=11 observed.
REQ-047 SHALL verify that DATA_W=8, SATURATE=1, A=[[100]], B=[[2]] -> C=127; A=[[-100]] -> C=-128; with SATURATE=0 -> C=0xC8.
REQ-048 SHALL verify random wait states of 0–7 cycles yield identical results, and that reset_n pulsed low during a WRITE -> outputs reset that cycle and the next enable gives a correct full job.
